// File: rtl/cordic_rot_pipe_if.sv
// Stream bundle for the CORDIC rotator front end: input sample handshake
// plus the x3/y3/ang3 result handshake.
interface cordic_rot_pipe_if #(
    parameter int unsigned W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic [W-1:0] ang_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] x3;
    logic [W-1:0] y3;
    logic [W-1:0] ang3;

    modport master (
        output in_valid, x_in, y_in, ang_in, out_ready,
        input  in_ready, out_valid, x3, y3, ang3
    );

    modport slave (
        input  in_valid, x_in, y_in, ang_in, out_ready,
        output in_ready, out_valid, x3, y3, ang3
    );
endinterface

// File: rtl/cordic_rot_pipe.sv
// CORDIC rotator front end: quadrant pre-rotation followed by micro-rotations
// i=0..2, four register stages with a single global stall.
module cordic_rot_pipe #(
    parameter int unsigned W       = 16,
    parameter int          HALF_PI = 12868,
    parameter int          ATAN0   = 6434,
    parameter int          ATAN1   = 3798,
    parameter int          ATAN2   = 2007
) (
    input  logic               clk,
    input  logic               reset,
    cordic_rot_pipe_if.slave   bus
);
    typedef logic signed [W-1:0] word_t;

    typedef struct packed {
        word_t x;
        word_t y;
        word_t z;
    } vec_t;

    localparam word_t HP_POS = word_t'(HALF_PI);
    localparam word_t HP_NEG = word_t'(-HALF_PI);

    vec_t [3:0] stg_q, stg_d;
    logic [3:0] vld_q, vld_d;
    logic       adv;
    vec_t       pre;

    // Rotation-mode step: zero residual angle rotates in the positive direction.
    function automatic vec_t micro_rot(vec_t v, int unsigned sh, word_t atan);
        vec_t r;
        if (!v.z[W-1]) begin
            r.x = v.x - (v.y >>> sh);
            r.y = v.y + (v.x >>> sh);
            r.z = v.z - atan;
        end else begin
            r.x = v.x + (v.y >>> sh);
            r.y = v.y - (v.x >>> sh);
            r.z = v.z + atan;
        end
        return r;
    endfunction

    always_comb begin
        pre.x = $signed(bus.x_in);
        pre.y = $signed(bus.y_in);
        pre.z = $signed(bus.ang_in);
        if ($signed(bus.ang_in) > HP_POS) begin
            pre.x = -$signed(bus.y_in);
            pre.y = $signed(bus.x_in);
            pre.z = $signed(bus.ang_in) - HP_POS;
        end else if ($signed(bus.ang_in) < HP_NEG) begin
            pre.x = $signed(bus.y_in);
            pre.y = -$signed(bus.x_in);
            pre.z = $signed(bus.ang_in) + HP_POS;
        end
    end

    always_comb begin
        adv   = !vld_q[3] || bus.out_ready;
        stg_d = stg_q;
        vld_d = vld_q;
        if (adv) begin
            vld_d    = {vld_q[2:0], bus.in_valid};
            stg_d[0] = pre;
            stg_d[1] = micro_rot(stg_q[0], 0, word_t'(ATAN0));
            stg_d[2] = micro_rot(stg_q[1], 1, word_t'(ATAN1));
            stg_d[3] = micro_rot(stg_q[2], 2, word_t'(ATAN2));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_q <= '0;
            vld_q <= '0;
        end else begin
            stg_q <= stg_d;
            vld_q <= vld_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[3];
    assign bus.x3        = stg_q[3].x;
    assign bus.y3        = stg_q[3].y;
    assign bus.ang3      = stg_q[3].z;
endmodule

// File: tb/tb_cordic_rot_pipe.sv
// Scoreboard bench for cordic_rot_pipe: directed vectors, stall, mid-stream
// reset and randomized traffic against an integer reference model.
module tb_cordic_rot_pipe;
    localparam int HALF_PI = 12868;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    int   low_start = -100;
    res_t exp_q[$];

    cordic_rot_pipe_if #(.W(16)) bus ();

    cordic_rot_pipe #(.W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sole driver of out_ready: random mode, or high except a scripted window.
    always @(negedge clk) begin
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) < 7);
        else          bus.out_ready = !(cyc >= low_start && cyc < low_start + 3);
    end

    function automatic res_t model(int x, int y, int a);
        int   atan_tab[3] = '{6434, 3798, 2007};
        int   xs = x, ys = y, z = a, t, d;
        res_t r;
        if (a > HALF_PI) begin
            xs = -y; ys = x; z = a - HALF_PI;
        end else if (a < -HALF_PI) begin
            xs = y; ys = -x; z = a + HALF_PI;
        end
        for (int i = 0; i < 3; i++) begin
            d  = (z >= 0) ? 1 : -1;
            t  = xs - d * (ys >>> i);
            ys = ys + d * (xs >>> i);
            xs = t;
            z  = z - d * atan_tab[i];
        end
        r.x = 16'(xs);
        r.y = 16'(ys);
        r.z = 16'(z);
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Holds the sample until accepted; expected result pushed on acceptance.
    task automatic send(int x, int y, int a, res_t e);
        int tries = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x_in = 16'(x);
        bus.y_in = 16'(y);
        bus.ang_in = 16'(a);
        #2;
        while (!bus.in_ready && tries < 50) begin
            @(negedge clk);
            #2;
            tries++;
        end
        if (!bus.in_ready) check("accept_timeout", 0, 1);
        else exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic res_t mk(int x, int y, int z);
        res_t r;
        r.x = 16'(x);
        r.y = 16'(y);
        r.z = 16'(z);
        return r;
    endfunction

    // Counts rising edges from acceptance (inclusive) until out_valid appears.
    task automatic latency_check(string name);
        int n = 1;
        bit seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #4;
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        check(name, n, 4);
    endtask

    // Monitor: pops and compares on every handshake; also checks in_ready.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset) begin
                check("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("x3", int'($signed(bus.x3)), int'(e.x));
                        check("y3", int'($signed(bus.y3)), int'(e.y));
                        check("ang3", int'($signed(bus.ang3)), int'(e.z));
                    end
                end
            end
        end
    end

    initial begin
        int x, y, a, w;
        bus.in_valid = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.ang_in = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_x3", int'(bus.x3), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        send(4096, 0, 0, mk(6656, 512, -629));
        latency_check("latency_t1");
        send(4096, 0, 12868, mk(512, 6656, 629));
        idle();
        send(4096, 0, 25736, mk(-6656, 512, 629));
        idle();
        send(4096, 0, -25736, model(4096, 0, -25736));
        send(1234, -5678, -12868, model(1234, -5678, -12868));
        send(-9000, 9000, -12869, model(-9000, 9000, -12869));
        idle();
        repeat (8) @(posedge clk);

        low_start = cyc + 3;
        for (int i = 0; i < 8; i++) begin
            x = 500 * i - 2000;
            y = 3000 - 700 * i;
            a = 6000 * i - 21000;
            send(x, y, a, model(x, y, a));
        end
        idle();
        repeat (10) @(posedge clk);

        for (int i = 0; i < 3; i++) begin
            send(1000 + i, 2000, 100 * i, model(1000 + i, 2000, 100 * i));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #5;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_x3", int'(bus.x3), 0);
        check("midrst_y3", int'(bus.y3), 0);
        check("midrst_ang3", int'(bus.ang3), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #5;
        reset = 1'b0;
        send(-3333, 4444, -20000, model(-3333, 4444, -20000));
        latency_check("latency_after_reset");
        repeat (4) @(posedge clk);

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(0, 18000)) - 9000;
            y = int'($urandom_range(0, 18000)) - 9000;
            a = int'($urandom_range(0, 51472)) - 25736;
            send(x, y, a, model(x, y, a));
        end
        idle();
        rand_rdy = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
